// File: rtl/karatsuba_82_seq_pkg.sv
// Shared widths, FSM encodings and the carry-less helper for the 82x82 GF(2) multiplier.
package karatsuba_82_seq_pkg;

   localparam int W  = 82;
   localparam int H  = 41;
   localparam int PW = 2 * H - 1;
   localparam int CW = 2 * W - 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_MUL_L = 3'd1;
   localparam logic [2:0] S_MUL_H = 3'd2;
   localparam logic [2:0] S_MUL_M = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   // Schoolbook carry-less product of two 21-bit polynomials (41-bit result).
   function automatic logic [40:0] clmul_21(input logic [20:0] x, input logic [20:0] y);
      logic [40:0] r;
      r = '0;
      for (int i = 0; i < 21; i++) begin
         if (y[i]) r = r ^ (41'(x) << i);
      end
      return r;
   endfunction

endpackage

// File: rtl/karatsuba_41x41.sv
// Combinational 41x41 carry-less multiplier, one Karatsuba level over 21/20-bit halves.
module karatsuba_41x41
   import karatsuba_82_seq_pkg::*;
(
   input  logic [40:0] a,
   input  logic [40:0] b,
   output logic [80:0] p
);

   logic [20:0] al, ah, bl, bh;
   logic [40:0] ll, hh, mm, mid;

   assign al = a[20:0];
   assign bl = b[20:0];
   assign ah = {1'b0, a[40:21]};
   assign bh = {1'b0, b[40:21]};

   assign ll  = clmul_21(al, bl);
   assign hh  = clmul_21(ah, bh);
   assign mm  = clmul_21(al ^ ah, bl ^ bh);
   assign mid = mm ^ ll ^ hh;

   // hh spans at most 39 bits, so shifting by 42 loses nothing.
   assign p = 81'(ll) ^ (81'(mid) << 21) ^ (81'(hh) << 42);

endmodule

// File: rtl/karatsuba_82_seq.sv
// Sequential 82x82 carry-less multiplier: one shared 41x41 core used for three
// sub-products over three cycles, with a valid/ready input and a held result.
module karatsuba_82_seq
   import karatsuba_82_seq_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] c,
   output logic          busy
);

   logic [2:0]    state;
   logic [W-1:0]  a_q, b_q;
   logic [PW-1:0] ll_q, hh_q;
   logic [CW-1:0] c_q;

   logic [H-1:0]  core_a, core_b;
   logic [PW-1:0] core_p;
   logic [PW-1:0] tmp;

   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      core_a = '0;
      core_b = '0;
      case (state)
         S_MUL_L: begin
            core_a = a_q[H-1:0];
            core_b = b_q[H-1:0];
         end
         S_MUL_H: begin
            core_a = a_q[W-1:H];
            core_b = b_q[W-1:H];
         end
         S_MUL_M: begin
            core_a = a_q[W-1:H] ^ a_q[H-1:0];
            core_b = b_q[W-1:H] ^ b_q[H-1:0];
         end
         default: ;
      endcase
   end

   karatsuba_41x41 u_core (
      .a (core_a),
      .b (core_b),
      .p (core_p)
   );

   // Middle term; the MUL_M product feeds c_q directly without an intermediate register.
   assign tmp = core_p ^ hh_q ^ ll_q;

   // NOTE: operand and partial registers are reset too, so a discarded operation leaves no residue.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         a_q   <= '0;
         b_q   <= '0;
         ll_q  <= '0;
         hh_q  <= '0;
         c_q   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  state <= S_MUL_L;
               end
            end
            S_MUL_L: begin
               ll_q  <= core_p;
               state <= S_MUL_H;
            end
            S_MUL_H: begin
               hh_q  <= core_p;
               state <= S_MUL_M;
            end
            S_MUL_M: begin
               c_q   <= {{(CW-PW){1'b0}}, ll_q}
                      ^ {{(CW-PW-H){1'b0}}, tmp, {H{1'b0}}}
                      ^ {hh_q, {W{1'b0}}};
               state <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state != S_IDLE);
   assign c         = c_q;

endmodule

// File: tb/tb_karatsuba_82_seq.sv
// Self-checking bench for karatsuba_82_seq: directed cases plus a scoreboarded random stream.
module tb_karatsuba_82_seq;
   import karatsuba_82_seq_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] c;
   logic          busy;

   logic [CW-1:0] sb_q[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   karatsuba_82_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .busy      (busy)
   );

   // Bit-serial carry-less reference product.
   function automatic logic [CW-1:0] ref_clmul(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [CW-1:0] r;
      r = '0;
      for (int i = 0; i < W; i++) begin
         if (y[i]) r = r ^ (CW'(x) << i);
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer an operand pair until accepted; the expected product is queued at acceptance.
   task automatic drive_op(input logic [W-1:0] av, input logic [W-1:0] bv, output bit to);
      int n;
      n  = 0;
      to = 1'b0;
      a  = av;
      b  = bv;
      in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      if (!in_ready) to = 1'b1;
      else sb_q.push_back(ref_clmul(av, bv));
      tick();
      in_valid = 1'b0;
   endtask

   // Count cycles until out_valid; flags any cycle where in_ready/busy disagree with a busy core.
   task automatic wait_out(output int cyc, output bit ctl_bad, output bit to);
      cyc     = 0;
      ctl_bad = 1'b0;
      to      = 1'b0;
      while (!out_valid && cyc < 100) begin
         if (in_ready || !busy) ctl_bad = 1'b1;
         tick();
         cyc++;
      end
      if (!out_valid) to = 1'b1;
      else if (in_ready || !busy) ctl_bad = 1'b1;
   endtask

   task automatic take_out(output logic [CW-1:0] got, output logic [CW-1:0] exp);
      got = c;
      exp = '0;
      if (sb_q.size() > 0) exp = sb_q.pop_front();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      #12;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
      end
      checks++;
      if (c !== '0) begin
         errors++;
         $display("FAIL reset_c: c=%h required 0", c);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      bit to, bad;
      int cyc;
      logic [CW-1:0] got, exp;
      drive_op(82'd1, 82'd1, to);
      wait_out(cyc, bad, to);
      checks++;
      if (to || cyc !== 3) begin
         errors++;
         $display("FAIL basic_latency: %0d cycles (timeout=%0b), required 3", cyc, to);
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL basic_busy_ctrl: in_ready high or busy low while working, required in_ready=0 busy=1");
      end
      take_out(got, exp);
      checks++;
      if (got !== CW'(1)) begin
         errors++;
         $display("FAIL basic_c: c=%h required 1", got);
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_boundaries();
      logic [W-1:0]  ta[4];
      logic [W-1:0]  tb_[4];
      logic [CW-1:0] tc[4];
      logic [CW-1:0] one_c;
      logic [W-1:0]  one_w;
      bit to, bad;
      int cyc;
      logic [CW-1:0] got, exp;
      one_w = 1;
      one_c = 1;
      ta[0] = 82'd3;        tb_[0] = 82'd3;        tc[0] = 163'd5;
      ta[1] = one_w << 41;  tb_[1] = one_w << 40;  tc[1] = one_c << 81;
      ta[2] = one_w << 81;  tb_[2] = one_w << 81;  tc[2] = one_c << 162;
      ta[3] = '1;           tb_[3] = one_w;        tc[3] = (one_c << 82) - one_c;
      for (int i = 0; i < 4; i++) begin
         drive_op(ta[i], tb_[i], to);
         wait_out(cyc, bad, to);
         take_out(got, exp);
         checks++;
         if (to || got !== tc[i]) begin
            errors++;
            $display("FAIL boundary_%0d: c=%h required %h (timeout=%0b)", i, got, tc[i], to);
         end
      end
   endtask

   task automatic test_backpressure();
      bit to, bad;
      int cyc;
      logic [CW-1:0] held, got, exp;
      logic [W-1:0]  av, bv;
      av = {$urandom(), $urandom(), 18'($urandom())};
      bv = {$urandom(), $urandom(), 18'($urandom())};
      drive_op(av, bv, to);
      wait_out(cyc, bad, to);
      held = c;
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         a = ~av;
         b = ~bv;
         tick();
         checks++;
         if (out_valid !== 1'b1 || c !== held || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_%0d: out_valid=%b in_ready=%b c=%h, required 1 0 %h", i, out_valid, in_ready, c, held);
         end
      end
      in_valid = 1'b0;
      take_out(got, exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL hold_result: c=%h required %h", got, exp);
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
      drive_op(82'd6, 82'd3, to);
      wait_out(cyc, bad, to);
      take_out(got, exp);
      checks++;
      if (to || got !== 163'd10 || sb_q.size() != 0) begin
         errors++;
         $display("FAIL hold_next: c=%h required a (queue=%0d)", got, sb_q.size());
      end
   endtask

   task automatic test_async_reset();
      bit to, bad, stale;
      int cyc;
      logic [CW-1:0] got, exp;
      drive_op(82'h3_ffff_0000_1234_5678_9abc, 82'h1_2345_6789_abcd_ef01_2345, to);
      tick();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: out_valid=%b in_ready=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
      end
      sb_q.delete();
      #3 rst_n = 1'b1;
      stale = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid) stale = 1'b1;
      end
      checks++;
      if (stale) begin
         errors++;
         $display("FAIL async_stale: out_valid seen after reset, required none");
      end
      drive_op(82'd5, 82'd7, to);
      wait_out(cyc, bad, to);
      take_out(got, exp);
      checks++;
      if (to || got !== 163'd27) begin
         errors++;
         $display("FAIL async_next: c=%h required 1b", got);
      end
   endtask

   task automatic test_back_to_back();
      localparam int N = 2000;
      int got_n;
      int drv_to;
      got_n  = 0;
      drv_to = 0;
      fork
         begin : driver
            bit to;
            logic [95:0] ra, rb;
            for (int i = 0; i < N; i++) begin
               repeat ($urandom_range(0, 2)) tick();
               ra = {$urandom(), $urandom(), $urandom()};
               rb = {$urandom(), $urandom(), $urandom()};
               if (i % 50 == 7) ra = '1;
               if (i % 50 == 9) rb = '1;
               drive_op(ra[W-1:0], rb[W-1:0], to);
               if (to) drv_to++;
            end
         end
         begin : monitor
            int cyc;
            logic [CW-1:0] exp;
            cyc = 0;
            while (got_n < N && cyc < 60000) begin
               out_ready = 1'($urandom_range(0, 1));
               if (out_valid && out_ready) begin
                  checks++;
                  if (sb_q.size() == 0) begin
                     errors++;
                     $display("FAIL b2b_unexpected: c=%h with empty scoreboard", c);
                  end else begin
                     exp = sb_q.pop_front();
                     if (c !== exp) begin
                        errors++;
                        $display("FAIL b2b_c[%0d]: c=%h required %h", got_n, c, exp);
                     end
                  end
                  got_n++;
               end
               tick();
               cyc++;
            end
            out_ready = 1'b0;
         end
      join
      checks++;
      if (got_n != N || sb_q.size() != 0 || drv_to != 0) begin
         errors++;
         $display("FAIL b2b_count: received %0d left %0d drive_timeouts %0d, required %0d 0 0", got_n, sb_q.size(), drv_to, N);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_backpressure();
      test_async_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
